// File: rtl/apu_mixer_i2s_if.sv
// rtl/apu_mixer_i2s_if.sv - CPU register access bus for the APU mixer
interface apu_mixer_i2s_if;
  logic       cpu_en;
  logic [1:0] target;
  logic [7:0] rdata;
  logic [7:0] wdata;
  logic       write;

  modport master (
    output cpu_en,
    output target,
    output wdata,
    output write,
    input  rdata
  );

  modport slave (
    input  cpu_en,
    input  target,
    input  wdata,
    input  write,
    output rdata
  );
endinterface

// File: rtl/apu_mixer_i2s.sv
// rtl/apu_mixer_i2s.sv - APU channel mixer with NR50/NR51 and I2S transmitter
module apu_mixer_i2s #(
  parameter int BCLK_DIV = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  apu_mixer_i2s_if.slave        bus,
  input  logic                  apu_on,
  input  logic [3:0]            ch1_wave,
  input  logic [3:0]            ch2_wave,
  input  logic [3:0]            ch3_wave,
  input  logic [3:0]            ch4_wave,
  output logic                  i2s_bclk,
  output logic                  i2s_lrck,
  output logic                  i2s_sdata,
  output logic                  frame_strobe
);

  localparam int DIV_W = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

  logic [7:0]       nr50;
  logic [7:0]       nr51;
  logic [DIV_W-1:0] div_cnt;
  logic [4:0]       slot;
  logic [4:0]       slot_next;
  logic [15:0]      hold_l;
  logic [15:0]      hold_r;
  logic [15:0]      hold_l_next;
  logic [15:0]      hold_r_next;
  logic [5:0]       sum_l;
  logic [5:0]       sum_r;
  logic [3:0]       vol_l;
  logic [3:0]       vol_r;
  logic [8:0]       mix_l;
  logic [8:0]       mix_r;
  logic [15:0]      sample_l;
  logic [15:0]      sample_r;
  logic             div_wrap;
  logic             bclk_fall;
  logic             frame_wrap;
  logic             next_bit;
  logic             next_lrck;

  // Register write path; power-off clears both registers and blocks writes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      nr50 <= 8'h00;
      nr51 <= 8'h00;
    end else if (!apu_on) begin
      nr50 <= 8'h00;
      nr51 <= 8'h00;
    end else begin
      if (bus.cpu_en && bus.write && bus.target[0]) nr50 <= bus.wdata;
      if (bus.cpu_en && bus.write && bus.target[1]) nr51 <= bus.wdata;
    end
  end

  // Read mux: NR50 wins when both select bits are set, no select reads all ones
  always_comb begin
    bus.rdata = 8'hFF;
    if (bus.target[0])      bus.rdata = nr50;
    else if (bus.target[1]) bus.rdata = nr51;
  end

  // Panning, master volume and left-justified placement into a 16-bit word
  always_comb begin
    sum_l = {2'b00, nr51[4] ? ch1_wave : 4'd0}
          + {2'b00, nr51[5] ? ch2_wave : 4'd0}
          + {2'b00, nr51[6] ? ch3_wave : 4'd0}
          + {2'b00, nr51[7] ? ch4_wave : 4'd0};
    sum_r = {2'b00, nr51[0] ? ch1_wave : 4'd0}
          + {2'b00, nr51[1] ? ch2_wave : 4'd0}
          + {2'b00, nr51[2] ? ch3_wave : 4'd0}
          + {2'b00, nr51[3] ? ch4_wave : 4'd0};
    vol_l = {1'b0, nr50[6:4]} + 4'd1;
    vol_r = {1'b0, nr50[2:0]} + 4'd1;
    mix_l = {3'b000, sum_l} * {5'b00000, vol_l};
    mix_r = {3'b000, sum_r} * {5'b00000, vol_r};
    sample_l = {1'b0, mix_l, 6'b000000};
    sample_r = {1'b0, mix_r, 6'b000000};
  end

  // Next-slot decode; on the frame wrap the freshly latched pair feeds slot 0
  always_comb begin
    div_wrap    = (div_cnt == DIV_LAST);
    bclk_fall   = div_wrap && i2s_bclk;
    slot_next   = slot + 5'd1;
    frame_wrap  = (slot == 5'd31);
    hold_l_next = frame_wrap ? sample_l : hold_l;
    hold_r_next = frame_wrap ? sample_r : hold_r;
    next_bit    = slot_next[4] ? hold_r_next[~slot_next[3:0]]
                               : hold_l_next[~slot_next[3:0]];
    next_lrck   = (slot_next >= 5'd15) && (slot_next <= 5'd30);
  end

  // Bit clock divider, slot counter and serial outputs, all advanced on bclk falls
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt      <= '0;
      slot         <= 5'd0;
      hold_l       <= 16'h0000;
      hold_r       <= 16'h0000;
      i2s_bclk     <= 1'b0;
      i2s_lrck     <= 1'b0;
      i2s_sdata    <= 1'b0;
      frame_strobe <= 1'b0;
    end else begin
      frame_strobe <= 1'b0;
      if (div_wrap) begin
        div_cnt  <= '0;
        i2s_bclk <= ~i2s_bclk;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      if (bclk_fall) begin
        slot      <= slot_next;
        i2s_lrck  <= next_lrck;
        i2s_sdata <= next_bit;
        if (frame_wrap) begin
          hold_l       <= sample_l;
          hold_r       <= sample_r;
          frame_strobe <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_apu_mixer_i2s.sv
// tb/tb_apu_mixer_i2s.sv - directed self-checking bench for apu_mixer_i2s
module tb_apu_mixer_i2s;

  localparam int BCLK_DIV = 8;

  logic       clk;
  logic       reset_n;
  logic       apu_on;
  logic [3:0] ch1_wave, ch2_wave, ch3_wave, ch4_wave;
  logic       i2s_bclk, i2s_lrck, i2s_sdata, frame_strobe;

  int tests_run;
  int tests_failed;

  apu_mixer_i2s_if bus ();

  apu_mixer_i2s #(.BCLK_DIV(BCLK_DIV)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus),
    .apu_on       (apu_on),
    .ch1_wave     (ch1_wave),
    .ch2_wave     (ch2_wave),
    .ch3_wave     (ch3_wave),
    .ch4_wave     (ch4_wave),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrck     (i2s_lrck),
    .i2s_sdata    (i2s_sdata),
    .frame_strobe (frame_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic reg_write(input logic [1:0] tgt, input logic [7:0] data, input logic en);
    @(negedge clk);
    bus.target = tgt;
    bus.wdata  = data;
    bus.write  = 1'b1;
    bus.cpu_en = en;
    @(negedge clk);
    bus.write  = 1'b0;
    bus.cpu_en = 1'b0;
  endtask

  task automatic reg_read(input string tag, input logic [1:0] tgt, input logic [7:0] exp);
    @(negedge clk);
    bus.target = tgt;
    #1;
    chk(tag, {24'h0, bus.rdata}, {24'h0, exp});
  endtask

  task automatic set_ch(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    ch1_wave = a; ch2_wave = b; ch3_wave = c; ch4_wave = d;
  endtask

  // Returns at the negedge where frame_strobe is seen high
  task automatic wait_strobe(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_strobe && n < 1200);
    if (!frame_strobe) chk({tag, "_strobe_timeout"}, 32'd0, 32'd1);
  endtask

  // Captures the 32 slots following a strobe, sampling at each bclk rise
  task automatic capture_frame(input string tag, output logic [15:0] l, output logic [15:0] r,
                               output logic [31:0] lr);
    logic [31:0] data;
    logic        pb;
    logic        found;
    int          n;
    data = '0;
    lr   = '0;
    for (int s = 0; s < 32; s++) begin
      pb = i2s_bclk;
      n  = 0;
      do begin
        @(negedge clk);
        n++;
        found = (pb == 1'b0) && (i2s_bclk == 1'b1);
        pb = i2s_bclk;
      end while (!found && n < 4 * BCLK_DIV);
      if (!found) begin
        chk({tag, "_bclk_timeout"}, 32'd0, 32'd1);
        break;
      end
      data  = {data[30:0], i2s_sdata};
      lr[s] = i2s_lrck;
    end
    l = data[31:16];
    r = data[15:0];
  endtask

  logic [15:0] cap_l, cap_r;
  logic [31:0] cap_lr;
  logic        sd_seen;
  int          cnt;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset_n      = 1'b0;
    apu_on       = 1'b1;
    bus.cpu_en   = 1'b0;
    bus.target   = 2'b00;
    bus.wdata    = 8'h00;
    bus.write    = 1'b0;
    set_ch(4'h0, 4'h0, 4'h0, 4'h0);
    repeat (4) @(negedge clk);
    reset_n = 1'b1;

    // Reset mid-frame with active audio
    reg_write(2'b01, 8'h77, 1'b1);
    reg_write(2'b10, 8'hFF, 1'b1);
    set_ch(4'hF, 4'hF, 4'hF, 4'hF);
    wait_strobe("pre_reset");
    repeat (200) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rst_bclk",   {31'h0, i2s_bclk},     32'd0);
    chk("rst_lrck",   {31'h0, i2s_lrck},     32'd0);
    chk("rst_sdata",  {31'h0, i2s_sdata},    32'd0);
    chk("rst_strobe", {31'h0, frame_strobe}, 32'd0);
    reg_read("rst_nr50", 2'b01, 8'h00);
    reg_read("rst_nr51", 2'b10, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    cnt = 0;
    sd_seen = 1'b0;
    do begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      sd_seen = sd_seen | i2s_sdata;
    end while (!frame_strobe && cnt < 2000);
    chk("first_strobe_clks", cnt, 32'd512);
    chk("first_frame_zero", {31'h0, sd_seen}, 32'd0);
    @(negedge clk);
    chk("strobe_one_clk", {31'h0, frame_strobe}, 32'd0);
    cnt = 1;
    while (!frame_strobe && cnt < 2000) begin
      @(negedge clk);
      cnt++;
    end
    chk("frame_period", cnt, 32'd512);

    // Readback and decode
    reg_write(2'b01, 8'hA5, 1'b1);
    reg_write(2'b10, 8'h3C, 1'b1);
    reg_read("rb_nr50", 2'b01, 8'hA5);
    reg_read("rb_nr51", 2'b10, 8'h3C);
    reg_write(2'b01, 8'h11, 1'b0);
    reg_write(2'b10, 8'h22, 1'b0);
    reg_read("noen_nr50", 2'b01, 8'hA5);
    reg_read("noen_nr51", 2'b10, 8'h3C);
    reg_read("tgt0_read", 2'b00, 8'hFF);
    reg_read("tgt3_read", 2'b11, 8'hA5);

    // Full scale
    reg_write(2'b01, 8'h77, 1'b1);
    reg_write(2'b10, 8'hFF, 1'b1);
    set_ch(4'hF, 4'hF, 4'hF, 4'hF);
    wait_strobe("full");
    capture_frame("full", cap_l, cap_r, cap_lr);
    chk("full_l",    {16'h0, cap_l}, 32'h7800);
    chk("full_r",    {16'h0, cap_r}, 32'h7800);
    chk("full_lrck", cap_lr,         32'h7FFF8000);

    // Panning and volume
    reg_write(2'b01, 8'h30, 1'b1);
    reg_write(2'b10, 8'h10, 1'b1);
    set_ch(4'hA, 4'hF, 4'hF, 4'hF);
    wait_strobe("pan");
    capture_frame("pan", cap_l, cap_r, cap_lr);
    chk("pan_l", {16'h0, cap_l}, 32'h0A00);
    chk("pan_r", {16'h0, cap_r}, 32'h0000);

    // Latch boundary
    reg_write(2'b01, 8'h00, 1'b1);
    reg_write(2'b10, 8'h11, 1'b1);
    set_ch(4'h1, 4'h0, 4'h0, 4'h0);
    wait_strobe("lb_prep");
    wait_strobe("lb");
    ch1_wave = 4'hF;
    capture_frame("lb0", cap_l, cap_r, cap_lr);
    chk("lb0_l", {16'h0, cap_l}, 32'h0040);
    chk("lb0_r", {16'h0, cap_r}, 32'h0040);
    wait_strobe("lb1");
    capture_frame("lb1", cap_l, cap_r, cap_lr);
    chk("lb1_l", {16'h0, cap_l}, 32'h03C0);
    chk("lb1_r", {16'h0, cap_r}, 32'h03C0);

    // Power off
    reg_write(2'b01, 8'h77, 1'b1);
    reg_write(2'b10, 8'hFF, 1'b1);
    set_ch(4'hF, 4'hF, 4'hF, 4'hF);
    @(negedge clk);
    apu_on = 1'b0;
    reg_read("off_nr50", 2'b01, 8'h00);
    reg_read("off_nr51", 2'b10, 8'h00);
    reg_write(2'b11, 8'h77, 1'b1);
    reg_read("off_wr_nr50", 2'b01, 8'h00);
    reg_read("off_wr_nr51", 2'b10, 8'h00);
    wait_strobe("off");
    capture_frame("off", cap_l, cap_r, cap_lr);
    chk("off_l", {16'h0, cap_l}, 32'h0000);
    chk("off_r", {16'h0, cap_r}, 32'h0000);
    apu_on = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
